// File: rtl/pecell_apb_regs.sv
// APB configuration/status slave for the PE cell: CTRL/THRESH config, live STATUS/ID,
// a saturating write-beat counter with coherent high-byte shadow, and a masked interrupt.
module pecell_apb_regs #(
  parameter int WAIT_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] pe_id,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [3:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  input  logic       wdata_valid,
  input  logic       wdata_busy,
  input  logic       wdata_last,
  input  logic       pe_busy,
  output logic       cfg_en,
  output logic [1:0] cfg_mode,
  output logic [7:0] cfg_thresh,
  output logic       irq
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  localparam logic [3:0] LP_WAIT    = 4'(WAIT_CYC);
  localparam logic [3:0] A_CTRL     = 4'h0;
  localparam logic [3:0] A_STATUS   = 4'h1;
  localparam logic [3:0] A_ID       = 4'h2;
  localparam logic [3:0] A_THRESH   = 4'h3;
  localparam logic [3:0] A_WCNT_L   = 4'h4;
  localparam logic [3:0] A_WCNT_H   = 4'h5;
  localparam logic [3:0] A_IRQ_STAT = 4'h6;
  localparam logic [3:0] A_IRQ_MASK = 4'h7;

  state_t      r_state;
  logic [3:0]  r_wait;
  logic [2:0]  r_ctrl;
  logic [7:0]  r_thresh;
  logic [15:0] r_wcnt;
  logic [7:0]  r_wcnt_shadow;
  logic [1:0]  r_irq_stat;
  logic [1:0]  r_irq_mask;
  logic        r_irq;

  logic        w_done;
  logic        w_wr;
  logic        w_rd;
  logic        w_addr_err;
  logic        w_wcnt_clr;
  logic        w_snapshot;
  logic        w_accept;
  logic        w_frame_done;
  logic [1:0]  w_w1c;

  // Handshake: a transfer completes on the rising edge where psel, penable and pready
  // are all high; pready depends only on registered FSM state, never on APB inputs.
  assign pready       = (r_state == S_ACCESS) && (r_wait == 4'd0);
  assign w_done       = psel & penable & pready;
  assign w_wr         = w_done & pwrite;
  assign w_rd         = w_done & ~pwrite;
  assign w_addr_err   = w_done & paddr[3];
  assign w_wcnt_clr   = w_wr & (paddr == A_WCNT_L);
  assign w_snapshot   = w_rd & (paddr == A_WCNT_L);
  assign w_accept     = wdata_valid & ~wdata_busy;
  assign w_frame_done = w_accept & wdata_last;
  assign w_w1c        = (w_wr && (paddr == A_IRQ_STAT)) ? pwdata[1:0] : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wait  <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (psel && !penable) begin
            r_state <= S_ACCESS;
            r_wait  <= LP_WAIT;
          end
        end
        S_ACCESS: begin
          if (!psel || w_done) begin
            r_state <= S_IDLE;
          end else if (r_wait != 4'd0) begin
            r_wait <= r_wait - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl     <= 3'd0;
      r_thresh   <= 8'd0;
      r_irq_mask <= 2'd0;
    end else if (w_wr) begin
      case (paddr)
        A_CTRL:     r_ctrl     <= pwdata[2:0];
        A_THRESH:   r_thresh   <= pwdata;
        A_IRQ_MASK: r_irq_mask <= pwdata[1:0];
        default: ;
      endcase
    end
  end

  // Clear has priority over a coincident beat; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt        <= 16'd0;
      r_wcnt_shadow <= 8'd0;
    end else if (w_wcnt_clr) begin
      r_wcnt        <= 16'd0;
      r_wcnt_shadow <= 8'd0;
    end else begin
      if (w_accept && (r_wcnt != 16'hFFFF)) r_wcnt <= r_wcnt + 16'd1;
      if (w_snapshot) r_wcnt_shadow <= r_wcnt[15:8];
    end
  end

  // New events win over a same-cycle write-1-to-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_stat <= 2'd0;
      r_irq      <= 1'b0;
    end else begin
      r_irq_stat <= (r_irq_stat & ~w_w1c) | {w_addr_err, w_frame_done};
      r_irq      <= |(r_irq_stat & r_irq_mask);
    end
  end

  always_comb begin
    prdata = 8'h00;
    if (pready && psel && !pwrite) begin
      case (paddr)
        A_CTRL:     prdata = {5'd0, r_ctrl};
        A_STATUS:   prdata = {6'd0, wdata_valid, pe_busy};
        A_ID:       prdata = {1'b0, pe_id};
        A_THRESH:   prdata = r_thresh;
        A_WCNT_L:   prdata = r_wcnt[7:0];
        A_WCNT_H:   prdata = r_wcnt_shadow;
        A_IRQ_STAT: prdata = {6'd0, r_irq_stat};
        A_IRQ_MASK: prdata = {6'd0, r_irq_mask};
        default:    prdata = 8'h00;
      endcase
    end
  end

  assign cfg_en     = r_ctrl[0];
  assign cfg_mode   = r_ctrl[2:1];
  assign cfg_thresh = r_thresh;
  assign irq        = r_irq;

endmodule

// File: tb/tb_pecell_apb_regs.sv
// Directed bench for pecell_apb_regs: two instances (1 and 3 wait states) share the
// clock, reset and write stream; each has its own psel.
module tb_pecell_apb_regs;

  localparam int W1 = 1;
  localparam int W3 = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] pe_id;
  logic       psel1, psel3, penable, pwrite;
  logic [3:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata1, prdata3;
  logic       pready1, pready3;
  logic       wdata_valid, wdata_busy, wdata_last, pe_busy;
  logic       cfg_en1, cfg_en3;
  logic [1:0] cfg_mode1, cfg_mode3;
  logic [7:0] cfg_thresh1, cfg_thresh3;
  logic       irq1, irq3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pecell_apb_regs #(.WAIT_CYC(W1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .pe_id(pe_id), .psel(psel1), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata1), .pready(pready1),
    .wdata_valid(wdata_valid), .wdata_busy(wdata_busy), .wdata_last(wdata_last),
    .pe_busy(pe_busy), .cfg_en(cfg_en1), .cfg_mode(cfg_mode1), .cfg_thresh(cfg_thresh1),
    .irq(irq1)
  );

  pecell_apb_regs #(.WAIT_CYC(W3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .pe_id(pe_id), .psel(psel3), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata3), .pready(pready3),
    .wdata_valid(wdata_valid), .wdata_busy(wdata_busy), .wdata_last(wdata_last),
    .pe_busy(pe_busy), .cfg_en(cfg_en3), .cfg_mode(cfg_mode3), .cfg_thresh(cfg_thresh3),
    .irq(irq3)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int which);
    return (which == 0) ? pready1 : pready3;
  endfunction

  // One APB transfer; returns at the falling edge after the completing rising edge.
  task automatic apb(input int which, input logic wr, input logic [3:0] addr,
                     input logic [7:0] data, input logic beat_at_done,
                     output logic [7:0] rdata, output int cyc);
    int n;
    @(negedge clk);
    if (which == 0) psel1 = 1'b1; else psel3 = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    cyc = 1;
    @(negedge clk);
    penable = 1'b1;
    cyc = 2;
    n = 0;
    while (!rdy(which) && n < 40) begin
      @(negedge clk);
      n++;
      cyc++;
    end
    chk("pready_seen", {15'd0, rdy(which)}, 16'd1);
    rdata = (which == 0) ? prdata1 : prdata3;
    if (beat_at_done) begin
      wdata_valid = 1'b1; wdata_busy = 1'b0; wdata_last = 1'b1;
    end
    @(negedge clk);
    psel1 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    wdata_valid = 1'b0; wdata_last = 1'b0;
  endtask

  task automatic rd(input int which, input logic [3:0] addr, input logic [7:0] exp,
                    input string tag);
    logic [7:0] d;
    int c;
    apb(which, 1'b0, addr, 8'h00, 1'b0, d, c);
    chk(tag, {8'd0, d}, {8'd0, exp});
    chk({tag, "_cyc"}, 16'(c), 16'(2 + ((which == 0) ? W1 : W3)));
  endtask

  task automatic wr(input int which, input logic [3:0] addr, input logic [7:0] data,
                    input logic beat_at_done);
    logic [7:0] d;
    int c;
    apb(which, 1'b1, addr, data, beat_at_done, d, c);
    chk("wr_cyc", 16'(c), 16'(2 + ((which == 0) ? W1 : W3)));
  endtask

  task automatic beats(input int n, input logic stall, input logic last_on_final);
    int acc;
    int i;
    acc = 0;
    i = 0;
    while (acc < n) begin
      @(negedge clk);
      wdata_valid = 1'b1;
      wdata_busy  = stall && (i % 3 == 1);
      wdata_last  = last_on_final && (acc == n - 1) && !wdata_busy;
      if (!wdata_busy) acc++;
      i++;
    end
    @(negedge clk);
    wdata_valid = 1'b0; wdata_busy = 1'b0; wdata_last = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_rd;
    rst_n = 1'b0; pe_id = 7'h2B; psel1 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = 4'h0; pwdata = 8'h00; wdata_valid = 1'b0;
    wdata_busy = 1'b0; wdata_last = 1'b0; pe_busy = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_pready", {15'd0, pready1}, 16'd0);
    chk("rst_prdata", {8'd0, prdata1}, 16'd0);
    chk("rst_cfg_en", {15'd0, cfg_en1}, 16'd0);
    chk("rst_cfg_mode", {14'd0, cfg_mode1}, 16'd0);
    chk("rst_cfg_thresh", {8'd0, cfg_thresh1}, 16'd0);
    chk("rst_irq", {15'd0, irq1}, 16'd0);

    // Read every address
    for (int a = 0; a < 16; a++) begin
      exp_rd = (a == 2) ? 8'h2B : 8'h00;
      rd(0, 4'(a), exp_rd, $sformatf("rd_all_%0h", a));
    end
    rd(0, 4'h6, 8'h02, "addr_err_set");
    chk("irq_masked", {15'd0, irq1}, 16'd0);

    // Config write/readback
    wr(0, 4'h0, 8'hFF, 1'b0);
    chk("cfg_en", {15'd0, cfg_en1}, 16'd1);
    chk("cfg_mode", {14'd0, cfg_mode1}, 16'd3);
    wr(0, 4'h3, 8'h5A, 1'b0);
    chk("cfg_thresh", {8'd0, cfg_thresh1}, 16'h005A);
    rd(0, 4'h0, 8'h07, "ctrl_rb");
    rd(0, 4'h3, 8'h5A, "thresh_rb");
    wr(0, 4'h1, 8'hFF, 1'b0);
    rd(0, 4'h6, 8'h02, "ro_write_no_err");
    wr(0, 4'h6, 8'h02, 1'b0);
    rd(0, 4'h6, 8'h00, "w1c_addr_err");

    // STATUS sampled live; stalled beat not counted
    pe_busy = 1'b1; wdata_valid = 1'b1; wdata_busy = 1'b1;
    rd(0, 4'h1, 8'h03, "status_live");
    pe_busy = 1'b0; wdata_busy = 1'b0;

    // Beat counter with stalls
    wr(0, 4'h4, 8'h00, 1'b0);
    beats(300, 1'b1, 1'b0);
    rd(0, 4'h4, 8'h2C, "wcnt_l");
    rd(0, 4'h5, 8'h01, "wcnt_h");
    wr(0, 4'h4, 8'hAA, 1'b0);
    rd(0, 4'h4, 8'h00, "wcnt_l_clr");
    rd(0, 4'h5, 8'h00, "wcnt_h_clr");

    // frame_done interrupt
    beats(1, 1'b0, 1'b1);
    wr(0, 4'h7, 8'h01, 1'b0);
    chk("irq_lag", {15'd0, irq1}, 16'd0);
    @(negedge clk);
    chk("irq_set", {15'd0, irq1}, 16'd1);
    wr(0, 4'h6, 8'h01, 1'b1);
    rd(0, 4'h6, 8'h01, "w1c_vs_set");
    chk("irq_held", {15'd0, irq1}, 16'd1);
    wr(0, 4'h6, 8'h01, 1'b0);
    chk("irq_clr_lag", {15'd0, irq1}, 16'd1);
    @(negedge clk);
    chk("irq_clr", {15'd0, irq1}, 16'd0);
    rd(0, 4'h6, 8'h00, "stat_clr");

    // Three wait states and aborted write
    rd(1, 4'h2, 8'h2B, "id_w3");
    wr(1, 4'h3, 8'h33, 1'b0);
    @(negedge clk);
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h3; pwdata = 8'h99;
    @(negedge clk);
    penable = 1'b1;
    chk("abort_pready0", {15'd0, pready3}, 16'd0);
    @(negedge clk);
    chk("abort_pready1", {15'd0, pready3}, 16'd0);
    psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    chk("abort_pready2", {15'd0, pready3}, 16'd0);
    chk("abort_cfg", {8'd0, cfg_thresh3}, 16'h0033);
    rd(1, 4'h3, 8'h33, "abort_thresh");

    // Reset during the completion cycle discards the write
    @(negedge clk);
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h0; pwdata = 8'h05;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    chk("pre_rst_pready", {15'd0, pready1}, 16'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_drop_pready", {15'd0, pready1}, 16'd0);
    @(negedge clk);
    psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("rst_discard_en", {15'd0, cfg_en1}, 16'd0);
    rd(0, 4'h0, 8'h00, "rst_discard_ctrl");

    // Saturation
    beats(65540, 1'b0, 1'b0);
    rd(0, 4'h4, 8'hFF, "sat_l");
    rd(0, 4'h5, 8'hFF, "sat_h");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
